// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ps2_state_e;

    // Start + 8 data + parity + stop
    localparam int unsigned PS2_FRAME_BITS      = 11;
    localparam int unsigned PS2_TIMEOUT_DEFAULT = 50000;

    // Odd parity: data bits plus parity bit must XOR to 1
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Show-ahead byte FIFO with extra-MSB pointers for full/empty detection.
module ps2_byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [7:0]  mem [DEPTH];
    logic        do_pop_c;
    logic        do_push_c;

    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop_c  = pop & ~empty;
    // A simultaneous pop frees the slot the push lands in
    assign do_push_c = push & (~full | do_pop_c);
    assign rd_data   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push_c) begin
                mem[wptr[AW-1:0]] <= wr_data;
                wptr              <= wptr + (AW+1)'(1);
            end
            if (do_pop_c) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver feeding a byte FIFO.
// Define PS2_RX_PARITY_CHECK_EN to drop bad-parity bytes and pulse parity_err.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned TIMEOUT_CYC = PS2_TIMEOUT_DEFAULT,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned SR_W  = PS2_FRAME_BITS - 1;
    localparam int unsigned BIT_W = $clog2(PS2_FRAME_BITS);

    logic [1:0]       clk_sync;
    logic [1:0]       dat_sync;
    logic             ps2_clk_s;
    logic             ps2_dat_s;
    logic             fclk;
    logic [FLT_W-1:0] flt_cnt;
    logic             fedge_c;
    logic             ffall_c;

    ps2_state_e       state;
    logic [SR_W-1:0]  sr;
    logic [BIT_W-1:0] bit_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             stop_ok_c;
    logic             par_ok_c;
    logic             push_c;
    logic             pop_c;
    logic             fifo_empty;
    logic             fifo_full;

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
        end
    end

    assign ps2_clk_s = clk_sync[1];
    assign ps2_dat_s = dat_sync[1];

    // Filtered clock flips on the FILTER_LEN-th consecutive differing sample
    assign fedge_c = (ps2_clk_s != fclk) && (flt_cnt == FLT_W'(FILTER_LEN - 1));
    assign ffall_c = fedge_c & fclk;

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            fclk    <= 1'b1;
            flt_cnt <= '0;
        end else if (ps2_clk_s == fclk) begin
            flt_cnt <= '0;
        end else if (fedge_c) begin
            fclk    <= ps2_clk_s;
            flt_cnt <= '0;
        end else begin
            flt_cnt <= flt_cnt + FLT_W'(1);
        end
    end

    assign stop_ok_c = sr[SR_W-1];
`ifdef PS2_RX_PARITY_CHECK_EN
    assign par_ok_c  = odd_parity_ok(sr[8:0]);
`else
    logic unused_parity_bit;
    assign unused_parity_bit = sr[SR_W-2];
    assign par_ok_c          = 1'b1;
`endif
    assign push_c = (state == DONE) && stop_ok_c && par_ok_c;
    assign pop_c  = rd_en & ~fifo_empty;

    // Frame FSM: sr collects data/parity/stop LSB first
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (push_c && fifo_full && !pop_c) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (ffall_c && !ps2_dat_s) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (fedge_c) begin
                        to_cnt <= '0;
                        if (ffall_c) begin
                            sr      <= {ps2_dat_s, sr[SR_W-1:1]};
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            if (bit_cnt == BIT_W'(SR_W - 1)) begin
                                state <= DONE;
                            end
                        end
                    end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (!stop_ok_c) begin
                        frame_err <= 1'b1;
                    end
`ifdef PS2_RX_PARITY_CHECK_EN
                    else if (!par_ok_c) begin
                        parity_err <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    ps2_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clock_25),
        .rst    (reset),
        .push   (push_c),
        .pop    (rd_en),
        .wr_data(sr[7:0]),
        .rd_data(rd_data),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    assign rd_valid = ~fifo_empty;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: directed PS/2 frames, monitor pops and checks bytes.
module tb_ps2_rx_fifo;

    localparam int unsigned TO    = 200;
    localparam int unsigned HALF  = 20;
    localparam int unsigned DEPTH = 8;

    logic       clock_25 = 1'b0;
    logic       reset;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    logic       pop_mode = 1'b1;
    logic [7:0] exp_q[$];

    ps2_rx_fifo #(
        .FILTER_LEN (4),
        .TIMEOUT_CYC(TO),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock_25  (clock_25),
        .reset     (reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #20 clock_25 = ~clock_25;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: pop whenever a byte is presented and compare against the scoreboard
    initial begin
        rd_en = 1'b0;
        forever begin
            @(negedge clock_25);
            rd_en = 1'b0;
            if (reset !== 1'b1 && rd_valid === 1'b1 && pop_mode) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", rd_data);
                end else begin
                    check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
                end
                rd_en = 1'b1;
            end
        end
    end

    always @(negedge clock_25) begin
        if (reset === 1'b0) begin
            if (parity_err === 1'b1) pe_cnt++;
            if (frame_err === 1'b1) fe_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock_25);
    endtask

    task automatic send_bit(input logic b);
        wait_neg(HALF / 2);
        PS2_DAT = b;
        wait_neg(HALF / 2);
        PS2_CLK = 1'b0;
        wait_neg(HALF);
        PS2_CLK = 1'b1;
    endtask

    // Full frame; optional exact latency check measured from the raw stop-bit fall
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit chk);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        wait_neg(HALF / 2);
        PS2_DAT = stop;
        wait_neg(HALF / 2);
        PS2_CLK = 1'b0;
        if (chk) begin
            for (int k = 1; k <= 7; k++) begin
                @(posedge clock_25);
                #1;
                if (k == 6) check("lat_early_valid", 32'(rd_valid), 32'(0));
                if (k == 7) begin
                    check("lat_valid", 32'(rd_valid), 32'(1));
                    check("lat_data", 32'(rd_data), 32'(d));
                end
            end
        end
        wait_neg(HALF);
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        wait_neg(HALF);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clock_25);
        wait_neg(3);
        check(name, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int fe0;
        int pe0;
        logic [7:0] v;

        reset   = 1'b1;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        wait_neg(3);
        check("rst_valid", 32'(rd_valid), 32'(0));
        check("rst_data", 32'(rd_data), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));
        check("rst_errs", 32'({parity_err, frame_err}), 32'(0));
        reset = 1'b0;
        wait_neg(10);

        // Good 0x1C frame with exact latency
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
        drain("drain_1c");
        check("1c_no_err", 32'(fe_cnt + pe_cnt), 32'(0));

        // Bad parity on 0x1C
        pe0 = pe_cnt;
`ifdef PS2_RX_PARITY_CHECK_EN
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        wait_neg(5);
        check("par_pulse", 32'(pe_cnt - pe0), 32'(1));
        check("par_no_push", 32'(rd_valid), 32'(0));
`else
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        drain("drain_par_ignored");
        check("par_tied0", 32'(pe_cnt - pe0), 32'(0));
`endif

        // Bad stop bit
        fe0 = fe_cnt;
        send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        wait_neg(5);
        check("stop_err", 32'(fe_cnt - fe0), 32'(1));
        check("stop_no_push", 32'(rd_valid), 32'(0));

        // Timeout after start + 4 bits; last filtered edge is the final rise
        fe0 = fe_cnt;
        v   = 8'hA5;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(v[i]);
        for (int k = 1; k <= int'(TO) + 6; k++) begin
            @(posedge clock_25);
            #1;
            if (k == int'(TO) + 5) check("to_early", 32'(frame_err), 32'(0));
            if (k == int'(TO) + 6) check("to_pulse", 32'(frame_err), 32'(1));
        end
        wait_neg(HALF);
        check("to_one_pulse", 32'(fe_cnt - fe0), 32'(1));
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, ~^8'hF0, 1'b1, 1'b0);
        drain("drain_f0");

        // Short low glitch while idle with data low
        fe0 = fe_cnt;
        PS2_DAT = 1'b0;
        PS2_CLK = 1'b0;
        wait_neg(2);
        PS2_CLK = 1'b1;
        wait_neg(5);
        PS2_DAT = 1'b1;
        wait_neg(int'(TO) + 20);
        check("glitch_no_err", 32'(fe_cnt - fe0), 32'(0));
        check("glitch_no_byte", 32'(rd_valid), 32'(0));
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, ~^8'h5A, 1'b1, 1'b0);
        drain("drain_5a");

        // Overflow: 9 frames with no pops
        pop_mode = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            v = 8'(i);
            if (i <= int'(DEPTH)) exp_q.push_back(v);
            send_frame(v, ~^v, 1'b1, 1'b0);
            if (i == int'(DEPTH)) check("ovf_not_yet", 32'(overflow), 32'(0));
        end
        check("ovf_set", 32'(overflow), 32'(1));
        pop_mode = 1'b1;
        drain("drain_ovf");
        check("ovf_empty", 32'(rd_valid), 32'(0));
        check("ovf_sticky", 32'(overflow), 32'(1));

        // Reset after 6 data bits
        v = 8'h3C;
        send_bit(1'b0);
        for (int i = 0; i < 6; i++) send_bit(v[i]);
        wait_neg(5);
        reset = 1'b1;
        wait_neg(2);
        check("mid_rst_valid", 32'(rd_valid), 32'(0));
        check("mid_rst_data", 32'(rd_data), 32'(0));
        check("mid_rst_ovf", 32'(overflow), 32'(0));
        check("mid_rst_errs", 32'({parity_err, frame_err}), 32'(0));
        wait_neg(3);
        reset = 1'b0;
        wait_neg(20);
        exp_q.push_back(8'h29);
        send_frame(8'h29, ~^8'h29, 1'b1, 1'b0);
        drain("drain_29");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
